// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: wait-stated RAM plus the keyboard, display and machine-control registers.
// Requests are handshaken with select/ready; each access takes effect at the edge that raises ready.
module lc3_mem_responder #(
   parameter int RAM_BITS    = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   input  logic        we,
   input  logic        select,
   output logic [15:0] data_out,
   output logic        ready,
   input  logic        kb_valid,
   input  logic [7:0]  kb_char,
   output logic [7:0]  disp_data,
   output logic        disp_valid,
   input  logic        disp_ack,
   output logic        kb_irq,
   output logic        mcr_run
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;
   localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
   localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t state, next_state;
   logic [3:0]  wait_cnt;
   logic [15:0] lat_addr, lat_data;
   logic        lat_we;
   logic [15:0] acc_addr, acc_data;
   logic        acc_we, commit, in_ram, kbdr_read, ddr_write;
   logic [15:0] io_rd, reg_q, ram_q, mcr;
   logic        out_from_ram, kb_full, kb_ie;
   logic [7:0]  kb_data;
   logic [15:0] mem [2**RAM_BITS];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (select) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT: if (wait_cnt == WAIT_LAST) next_state = RESP;
         RESP: next_state = HOLD;
         HOLD: if (!select) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == RESP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= 4'd0;
         lat_addr <= 16'h0000;
         lat_data <= 16'h0000;
         lat_we   <= 1'b0;
      end else if (state == IDLE && select) begin
         wait_cnt <= 4'd0;
         lat_addr <= addr;
         lat_data <= data_in;
         lat_we   <= we;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // With zero wait states the access commits on the same edge it is latched, so use live inputs then.
   always_comb begin
      acc_addr  = (state == IDLE) ? addr    : lat_addr;
      acc_data  = (state == IDLE) ? data_in : lat_data;
      acc_we    = (state == IDLE) ? we      : lat_we;
      commit    = (next_state == RESP);
      in_ram    = (({16'h0000, acc_addr} >> RAM_BITS) == 32'd0);
      kbdr_read = commit && !acc_we && (acc_addr == KBDR_ADDR);
      ddr_write = commit && acc_we && (acc_addr == DDR_ADDR);
      io_rd     = 16'h0000;
      case (acc_addr)
         KBSR_ADDR: io_rd = {kb_full, kb_ie, 14'b0};
         KBDR_ADDR: io_rd = {8'h00, kb_data};
         DSR_ADDR:  io_rd = {~disp_valid, 15'b0};
         MCR_ADDR:  io_rd = mcr;
         default:   io_rd = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (commit && !reset && in_ram) begin
         ram_q <= mem[acc_addr[RAM_BITS-1:0]];
         if (acc_we) mem[acc_addr[RAM_BITS-1:0]] <= acc_data;
      end
   end

   // A full keyboard buffer only accepts a new character when the same edge reads it out.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_q        <= 16'h0000;
         out_from_ram <= 1'b0;
         kb_full      <= 1'b0;
         kb_ie        <= 1'b0;
         kb_data      <= 8'h00;
         kb_irq       <= 1'b0;
         disp_valid   <= 1'b0;
         disp_data    <= 8'h00;
         mcr          <= 16'h8000;
      end else begin
         if (commit) begin
            out_from_ram <= in_ram && !acc_we;
            reg_q        <= (acc_we || in_ram) ? 16'h0000 : io_rd;
            if (acc_we && acc_addr == KBSR_ADDR) kb_ie <= acc_data[14];
            if (acc_we && acc_addr == MCR_ADDR)  mcr   <= acc_data;
         end
         if (kb_valid && (!kb_full || kbdr_read)) begin
            kb_data <= kb_char;
            kb_full <= 1'b1;
         end else if (kbdr_read) begin
            kb_full <= 1'b0;
         end
         kb_irq <= kb_full & kb_ie;
         if (ddr_write && (!disp_valid || disp_ack)) begin
            disp_data  <= acc_data[7:0];
            disp_valid <= 1'b1;
         end else if (disp_ack) begin
            disp_valid <= 1'b0;
         end
      end
   end

   assign data_out = out_from_ram ? ram_q : reg_q;
   assign mcr_run  = mcr[15];

endmodule
